des_block_serializer: RTL

DES_BLOCK_SERIALIZER -- requirements
Module: des_block_serializer

---
 rtl/des_pkg.sv | 27 ++
 rtl/des_block_serializer_hold.sv | 21 ++
 rtl/des_block_serializer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared widths, FSM state encoding and byte-selection helpers for the DES block serializer.
package des_pkg;

    localparam int DES_BLOCK_W       = 64;
    localparam int DES_BYTE_W        = 8;
    localparam int DES_BYTES_PER_BLK = 8;
    localparam int DES_CNT_W         = $clog2(DES_BYTES_PER_BLK);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    typedef logic [DES_BLOCK_W-1:0] blk_t;
    typedef logic [DES_BYTE_W-1:0]  byte_t;

    // The byte currently presented sits at the top of the register for MSB-first
    // order and at the bottom for LSB-first order.
    function automatic byte_t head_byte(input blk_t b, input bit msb_first);
        return msb_first ? b[DES_BLOCK_W-1 -: DES_BYTE_W] : b[DES_BYTE_W-1:0];
    endfunction

    function automatic blk_t shift_out(input blk_t b, input bit msb_first);
        return msb_first ? (b << DES_BYTE_W) : (b >> DES_BYTE_W);
    endfunction

endpackage

// File: rtl/des_block_serializer_hold.sv
// des_blk_hold: 64-bit load-enabled register, async active-high reset.
// Latency 1 cycle from en to q; no flow control of its own.
module des_blk_hold
    import des_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  blk_t d,
    output blk_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/des_block_serializer.sv
// Splits 64-bit DES blocks into 8 bytes; first byte valid 1 cycle after accept.
// Backpressure: bytes hold while out_ready=0; in_ready opens on the last-byte handshake,
// or with DES_SER_BUF_EN a one-block holding register absorbs the next block early.
module des_block_serializer
    import des_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:64] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    localparam bit MSB_SEL = (MSB_FIRST != 0);

    ser_state_t           state;
    logic [DES_CNT_W-1:0] cnt;
    blk_t                 sr_q;
    blk_t                 sr_d;
    blk_t                 blk_in;
    logic                 sr_en;
    logic                 load;
    logic                 accept;
    logic                 out_hs;
    logic                 last_hs;

    // in_data bit 1 lands on blk_in[63], so the DES MSB is the register MSB.
    assign blk_in    = in_data;

    assign out_valid = (state == ST_SHIFT);
    assign out_data  = head_byte(sr_q, MSB_SEL);
    assign out_last  = out_valid && (cnt == DES_CNT_W'(DES_BYTES_PER_BLK - 1));
    assign out_hs    = out_valid && out_ready;
    assign last_hs   = out_last && out_ready;
    assign accept    = in_valid && in_ready;

`ifdef DES_SER_BUF_EN
    blk_t hold_q;
    logic full;
    logic take_direct;
    logic take_hold;
    logic pop_hold;

    assign in_ready    = !reset && ((state == ST_IDLE) || !full);
    // A block goes straight into the shift register only when nothing is queued ahead of it.
    assign take_direct = accept && ((state == ST_IDLE) || (last_hs && !full));
    assign take_hold   = accept && !take_direct;
    assign pop_hold    = last_hs && full;
    assign load        = take_direct || pop_hold;
    assign sr_d        = take_direct ? blk_in : (pop_hold ? hold_q : shift_out(sr_q, MSB_SEL));
    assign sr_en       = load || out_hs;
    assign busy        = (state == ST_SHIFT) || full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
        end else begin
            full <= take_hold || (full && !pop_hold);
        end
    end

    des_blk_hold u_hold (
        .clk   (clk),
        .reset (reset),
        .en    (take_hold),
        .d     (blk_in),
        .q     (hold_q)
    );
`else
    assign in_ready = !reset && ((state == ST_IDLE) || last_hs);
    assign load     = accept;
    assign sr_d     = accept ? blk_in : shift_out(sr_q, MSB_SEL);
    assign sr_en    = accept || out_hs;
    assign busy     = (state == ST_SHIFT);
`endif

    des_blk_hold u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (sr_en),
        .d     (sr_d),
        .q     (sr_q)
    );

    // A load coinciding with the last-byte handshake keeps SHIFT; the counter wraps to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (out_hs) begin
                        cnt <= cnt + 1'b1;
                        if (last_hs && !load) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
